// File: rtl/apb_modport_pkg.sv
// Shared definitions for the APB two-slave subsystem: default widths,
// master FSM state encoding and the read/write direction constants.
package apb_modport_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage : apb_modport_pkg

// File: rtl/apb_modport_if.sv
// Interfaces for the APB subsystem.
// apb_modport_if : user request channel (requester = master, bridge = slave).
// apb_bus_if     : one APB3 link between the bridge and a memory slave;
//                  IW is the word-index width seen by that slave.
interface apb_modport_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_read_data_out;

  modport master (
    output transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    input  apb_read_data_out
  );

  modport slave (
    input  transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    output apb_read_data_out
  );
endinterface : apb_modport_if

interface apb_bus_if #(
  parameter int IW = 8,
  parameter int DW = 8
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [IW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface : apb_bus_if

// File: rtl/apb_modport_mem_slave.sv
// APB memory slave: 2**IW words of DW bits, cleared by reset.
// Reads are combinational from the addressed word; writes land on the
// edge that completes ACCESS.
// Build option APB_SLV_WAIT_EN: when defined, each transfer gets one wait
// state (pready low in the first ACCESS cycle, high in the second);
// otherwise pready is tied high.
module apb_mem_slave #(
  parameter int IW = 8,
  parameter int DW = 8
) (
  input  logic       pclk,
  input  logic       presetn,
  apb_bus_if.slave   bus
);

  logic [DW-1:0] mem [2**IW];

  // Memory array: cleared on reset, written on a completing write ACCESS
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 2**IW; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.psel && bus.penable && bus.pwrite && bus.pready) begin
      mem[bus.paddr] <= bus.pwdata;
    end
  end

  assign bus.prdata = mem[bus.paddr];

`ifdef APB_SLV_WAIT_EN
  logic wait_done;

  // Wait-state tracker: set after the first ACCESS cycle, cleared once the transfer completes
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_done <= 1'b0;
    end else begin
      wait_done <= bus.psel && bus.penable && !wait_done;
    end
  end

  assign bus.pready = wait_done;
`else
  assign bus.pready = 1'b1;
`endif

endmodule : apb_mem_slave

// File: rtl/apb_modport.sv
// APB subsystem top: an APB3 master bridge driving two memory slaves.
// paddr[AW-1] picks the slave, paddr[AW-2:0] is the word index.
// Wait-state behaviour of the slaves is set by APB_SLV_WAIT_EN
// (see apb_mem_slave).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; waits for transfer=1, latches the request
// SETUP  | psel high, penable low; always advances to ACCESS
// ACCESS | psel+penable high; completes on pready, chains or idles
module apb_modport
  import apb_modport_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_modport_if.slave  user
);

  apb_state_e    state, state_nxt;
  logic          load;
  logic          complete;
  logic          psel1, psel2, penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready_sel;
  logic [DW-1:0] prdata_sel;
  logic [DW-1:0] rdata_q;

  apb_bus_if #(.IW(AW-1), .DW(DW)) bus1 ();
  apb_bus_if #(.IW(AW-1), .DW(DW)) bus2 ();

  assign bus1.psel    = psel1;
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr[AW-2:0];
  assign bus1.pwdata  = pwdata;

  assign bus2.psel    = psel2;
  assign bus2.penable = penable;
  assign bus2.pwrite  = pwrite;
  assign bus2.paddr   = paddr[AW-2:0];
  assign bus2.pwdata  = pwdata;

  apb_mem_slave #(.IW(AW-1), .DW(DW)) u_slave1 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus1)
  );

  apb_mem_slave #(.IW(AW-1), .DW(DW)) u_slave2 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus2)
  );

  // Only the selected slave's response matters to the bridge
  assign pready_sel = paddr[AW-1] ? bus2.pready : bus1.pready;
  assign prdata_sel = paddr[AW-1] ? bus2.prdata : bus1.prdata;

  // Master FSM state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, request-latch strobe and bus control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    complete  = 1'b0;
    psel1     = 1'b0;
    psel2     = 1'b0;
    penable   = 1'b0;
    case (state)
      IDLE: begin
        if (user.transfer) begin
          state_nxt = SETUP;
          load      = 1'b1;
        end
      end
      SETUP: begin
        psel1     = ~paddr[AW-1];
        psel2     = paddr[AW-1];
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel1   = ~paddr[AW-1];
        psel2   = paddr[AW-1];
        penable = 1'b1;
        if (pready_sel) begin
          complete = 1'b1;
          if (user.transfer) begin
            state_nxt = SETUP;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch: user inputs are only sampled when a new transfer starts
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (load) begin
      pwrite <= (user.read_write == WRITE);
      paddr  <= (user.read_write == READ) ? user.apb_read_paddr : user.apb_write_paddr;
      pwdata <= user.apb_write_data;
    end
  end

  // Read data capture on the completing ACCESS edge of a read; held otherwise
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rdata_q <= '0;
    end else if (complete && !pwrite) begin
      rdata_q <= prdata_sel;
    end
  end

  assign user.apb_read_data_out = rdata_q;

endmodule : apb_modport

// File: tb/tb_apb_modport.sv
// Directed bench for apb_modport: reset, latency, slave decode,
// back-to-back chaining, address boundaries and reset during ACCESS.
module tb_apb_modport;
  import apb_modport_pkg::*;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  int   total   = 0;
  int   bad     = 0;

`ifdef APB_SLV_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  always #5 pclk = ~pclk;

  apb_modport_if #(.AW(9), .DW(8)) u_if ();

  apb_modport #(.AW(9), .DW(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .user    (u_if)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic [8:0] a, input logic [7:0] d);
    u_if.read_write = rw;
    if (rw == READ) u_if.apb_read_paddr = a;
    else            u_if.apb_write_paddr = a;
    u_if.apb_write_data = d;
  endtask

  // Present one request before an edge; returns #1 after the latching edge
  task automatic req(input logic rw, input logic [8:0] a, input logic [7:0] d);
    @(negedge pclk);
    set_in(rw, a, d);
    u_if.transfer = 1'b1;
    @(posedge pclk);
    #1;
    u_if.transfer = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (dut.state !== IDLE && n < 8) begin
      @(posedge pclk);
      #1;
      n++;
    end
    chk(tag, 16'(dut.state), 16'(IDLE));
  endtask

  task automatic xfer(input logic rw, input logic [8:0] a, input logic [7:0] d, input string tag);
    req(rw, a, d);
    wait_idle(tag);
  endtask

  task automatic rd_chk(input logic [8:0] a, input logic [7:0] exp, input string tag);
    xfer(READ, a, 8'h00, {tag, "_idle"});
    chk(tag, 16'(u_if.apb_read_data_out), 16'(exp));
  endtask

  initial begin
    logic       rw_v [4];
    logic [8:0] a_v  [4];
    logic [7:0] d_v  [4];
    int         n;

    u_if.transfer        = 1'b0;
    u_if.read_write      = 1'b0;
    u_if.apb_write_paddr = '0;
    u_if.apb_write_data  = '0;
    u_if.apb_read_paddr  = '0;

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_rdata",   16'(u_if.apb_read_data_out), 16'h0);
    chk("rst_state",   16'(dut.state), 16'(IDLE));
    chk("rst_psel1",   16'(dut.psel1), 16'h0);
    chk("rst_psel2",   16'(dut.psel2), 16'h0);
    chk("rst_penable", 16'(dut.penable), 16'h0);
    @(negedge pclk);
    presetn = 1'b1;

    rd_chk(9'h0A5, 8'h00, "rst_rd_0a5");
    rd_chk(9'h1A5, 8'h00, "rst_rd_1a5");

    // Write then read with exact latency
    xfer(WRITE, 9'h0A5, 8'h3C, "wr_0a5");
    req(READ, 9'h0A5, 8'h00);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge pclk);
      #1;
      if (k < LAT) chk("lat_early", 16'(u_if.apb_read_data_out), 16'h00);
      else         chk("lat_done",  16'(u_if.apb_read_data_out), 16'h3C);
    end
    wait_idle("lat_idle");

    // Slave decode
    req(WRITE, 9'h005, 8'h11);
    chk("dec_s1_psel1", 16'(dut.psel1), 16'h1);
    chk("dec_s1_psel2", 16'(dut.psel2), 16'h0);
    wait_idle("dec_s1_idle");
    req(WRITE, 9'h105, 8'h22);
    chk("dec_s2_psel1", 16'(dut.psel1), 16'h0);
    chk("dec_s2_psel2", 16'(dut.psel2), 16'h1);
    wait_idle("dec_s2_idle");
    rd_chk(9'h005, 8'h11, "dec_rd_005");
    rd_chk(9'h105, 8'h22, "dec_rd_105");

    // Reset while idle clears read data and memories
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("idle_rst_rdata", 16'(u_if.apb_read_data_out), 16'h00);
    chk("idle_rst_state", 16'(dut.state), 16'(IDLE));
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    rd_chk(9'h105, 8'h00, "idle_rst_rd_105");
    rd_chk(9'h005, 8'h00, "idle_rst_rd_005");

    // Back-to-back: transfer held high across four requests
    rw_v[0] = WRITE; a_v[0] = 9'h010; d_v[0] = 8'hAA;
    rw_v[1] = WRITE; a_v[1] = 9'h110; d_v[1] = 8'h55;
    rw_v[2] = READ;  a_v[2] = 9'h010; d_v[2] = 8'hAA;
    rw_v[3] = READ;  a_v[3] = 9'h110; d_v[3] = 8'h55;
    @(negedge pclk);
    set_in(rw_v[0], a_v[0], d_v[0]);
    u_if.transfer = 1'b1;
    @(posedge pclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_setup", 16'(dut.state), 16'(SETUP));
      if (i < 3) set_in(rw_v[i+1], a_v[i+1], d_v[i+1]);
      else       u_if.transfer = 1'b0;
      n = 0;
      do begin
        @(posedge pclk);
        #1;
        n++;
      end while (dut.state != SETUP && dut.state != IDLE && n < 8);
      chk("b2b_cycles", 16'(n), 16'(LAT));
      if (rw_v[i] == READ) chk("b2b_rdata", 16'(u_if.apb_read_data_out), 16'(d_v[i]));
    end
    chk("b2b_end_idle", 16'(dut.state), 16'(IDLE));

    // Address boundaries
    xfer(WRITE, 9'h0FF, 8'hFF, "bnd_wr_0ff");
    xfer(WRITE, 9'h1FF, 8'h80, "bnd_wr_1ff");
    rd_chk(9'h000, 8'h00, "bnd_rd_000");
    rd_chk(9'h0FF, 8'hFF, "bnd_rd_0ff");
    rd_chk(9'h1FF, 8'h80, "bnd_rd_1ff");
    rd_chk(9'h010, 8'hAA, "bnd_rd_010");

    // Reset during ACCESS of a write aborts it
    req(WRITE, 9'h033, 8'h77);
    @(posedge pclk);
    #1;
    chk("abort_in_access", 16'(dut.state), 16'(ACCESS));
    #2;
    presetn = 1'b0;
    #1;
    chk("abort_state",   16'(dut.state), 16'(IDLE));
    chk("abort_penable", 16'(dut.penable), 16'h0);
    @(negedge pclk);
    presetn = 1'b1;
    rd_chk(9'h033, 8'h00, "abort_rd_033");
    rd_chk(9'h0FF, 8'h00, "abort_rd_0ff");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_apb_modport
